// File: rtl/ripple_adder_pkg.sv
// rtl/ripple_adder_pkg.sv - shared width constant and vector types for the ripple adder
package ripple_adder_pkg;

    localparam int WIDTH = 4;

    // One operand, LSB at index 0
    typedef logic [WIDTH-1:0] operand_t;

    // Carry-out in the MSB, sum below it
    typedef logic [WIDTH:0] result_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder, one stage of the carry ripple
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    // Propagate term is shared by the sum and the carry
    always_comb begin
        half_sum = a ^ b;
        s        = half_sum ^ cin;
        cout     = (a & b) | (cin & half_sum);
    end

endmodule

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - 4-bit registered ripple-carry adder; optional ovf port under RIPPLE_ADDER_OVF_EN
module ripple_adder
    import ripple_adder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic cin0,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
`ifdef RIPPLE_ADDER_OVF_EN
    output logic ovf,
`endif
    output logic cout
);

    operand_t       a_vec;
    operand_t       b_vec;
    operand_t       sum_vec;
    logic [WIDTH:0] carry;     // carry[i] feeds bit i; carry[WIDTH] is the carry-out
    result_t        result_d;
    result_t        result_q;

    assign a_vec    = {a3, a2, a1, a0};
    assign b_vec    = {b3, b2, b1, b0};
    assign carry[0] = cin0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a_vec[i]),
            .b    (b_vec[i]),
            .cin  (carry[i]),
            .s    (sum_vec[i]),
            .cout (carry[i+1])
        );
    end

    assign result_d = {carry[WIDTH], sum_vec};

    // Output register bank: cleared immediately by reset, otherwise loads a new result every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign {cout, s3, s2, s1, s0} = result_q;

`ifdef RIPPLE_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: carry into the sign bit disagrees with carry out of it
    assign ovf_d = carry[WIDTH-1] ^ carry[WIDTH];

    // Overflow flag registered alongside the sum so both share the same latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_adder.sv
// tb/tb_ripple_adder.sv - self-checking bench for ripple_adder; checks ovf when RIPPLE_ADDER_OVF_EN is defined
module tb_ripple_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic a0, a1, a2, a3;
    logic b0, b1, b2, b3;
    logic cin0;
    logic s0, s1, s2, s3;
    logic cout;
`ifdef RIPPLE_ADDER_OVF_EN
    logic ovf;
`endif

    int checks = 0;
    int errors = 0;

    ripple_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .b0    (b0),
        .b1    (b1),
        .b2    (b2),
        .b3    (b3),
        .cin0  (cin0),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .s3    (s3),
`ifdef RIPPLE_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [4:0] res;
        logic       ov;
    } vec_t;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] dut_res();
        return {cout, s3, s2, s1, s0};
    endfunction

    // Reference: plain integer addition, no bit-level structure
    function automatic logic [4:0] ref_sum(input int a, input int b, input int c);
        int total;
        total = a + b + c;
        return total[4:0];
    endfunction

    // Reference: operands read as two's complement, flag when the true sum leaves -8..7
    function automatic logic ref_ovf(input int a, input int b, input int c);
        int sa, sb, total;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        total = sa + sb + c;
        return (total > 7) || (total < -8);
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        {a3, a2, a1, a0} = a;
        {b3, b2, b1, b0} = b;
        cin0 = c;
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef RIPPLE_ADDER_OVF_EN
        check(tag, {4'b0, ovf}, {4'b0, exp});
`else
        if (exp === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic apply_model(input string tag, input int a, input int b, input int c);
        @(negedge clk);
        drive(a[3:0], b[3:0], c[0]);
        @(posedge clk);
        #1;
        check(tag, dut_res(), ref_sum(a, b, c));
        check_ovf({tag, "_ovf"}, ref_ovf(a, b, c));
    endtask

    vec_t dir [8];

    initial begin
        dir[0] = '{a: 4'd0,  b: 4'd3,  c: 1'b0, res: 5'b0_0011, ov: 1'b0};
        dir[1] = '{a: 4'd0,  b: 4'd11, c: 1'b0, res: 5'b0_1011, ov: 1'b0};
        dir[2] = '{a: 4'd8,  b: 4'd3,  c: 1'b0, res: 5'b0_1011, ov: 1'b0};
        dir[3] = '{a: 4'd8,  b: 4'd11, c: 1'b0, res: 5'b1_0011, ov: 1'b1};
        dir[4] = '{a: 4'd15, b: 4'd0,  c: 1'b1, res: 5'b1_0000, ov: 1'b0};
        dir[5] = '{a: 4'd0,  b: 4'd15, c: 1'b0, res: 5'b0_1111, ov: 1'b0};
        dir[6] = '{a: 4'd7,  b: 4'd1,  c: 1'b0, res: 5'b0_1000, ov: 1'b1};
        dir[7] = '{a: 4'd7,  b: 4'd0,  c: 1'b0, res: 5'b0_0111, ov: 1'b0};

        // Reset held with random inputs: outputs must read zero
        rst_n = 1'b0;
        drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
        #2;
        check("reset_async", dut_res(), 5'b0);
        check_ovf("reset_async_ovf", 1'b0);
        #15;
        check("reset_held", dut_res(), 5'b0);

        // First edge after release captures the live sum
        begin
            int a, b, c;
            a = $urandom_range(15);
            b = $urandom_range(15);
            c = $urandom_range(1);
            @(negedge clk);
            rst_n = 1'b1;
            drive(a[3:0], b[3:0], c[0]);
            @(posedge clk);
            #1;
            check("release_first", dut_res(), ref_sum(a, b, c));
        end

        // Directed cases with literal expected values
        foreach (dir[i]) begin
            @(negedge clk);
            drive(dir[i].a, dir[i].b, dir[i].c);
            @(posedge clk);
            #1;
            check($sformatf("dir%0d", i), dut_res(), dir[i].res);
            check_ovf($sformatf("dir%0d_ovf", i), dir[i].ov);
        end

        // Exhaustive sweep of {cin0, A, B}, with an asynchronous reset in the middle
        for (int idx = 0; idx < 512; idx++) begin
            apply_model($sformatf("sweep%0d", idx), (idx >> 4) & 15, idx & 15, idx >> 8);
            if (idx == 256) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("midsweep_clear", dut_res(), 5'b0);
                check_ovf("midsweep_clear_ovf", 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // Random back-to-back stimulus
        for (int n = 0; n < 64; n++) begin
            apply_model($sformatf("rand%0d", n), $urandom_range(15), $urandom_range(15), $urandom_range(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
